frame_infer_sched: RTL and testbench

- Frame-level scheduler between the camera/VGA timing path and the cam2cnn inference datapath.
- Decides which frames get captured and when inference starts. Checks that each capture is complete and guards against a hung CNN with a timeout.
- Debounces per-frame digits with a consecutive-agreement vote before driving the 7-segment/LED outputs.

---
 rtl/frame_infer_pkg.sv | 22 ++
 rtl/digit_vote.sv | 45 ++++
 rtl/frame_infer_sched.sv | 151 +++++++++++++++
 tb/tb_frame_infer_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_infer_pkg.sv
// Shared types and helpers for the frame-level inference scheduler.
package frame_infer_pkg;

  typedef enum logic [2:0] {
    ARM,
    CAPTURE,
    CHECK,
    START,
    WAIT_DONE,
    VOTE,
    SKIP
  } sched_state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_NONE = 4'hF;

  // Camera pixels expected inside the capture box for one frame.
  function automatic int box_pixels(input int dim, input int mult);
    return (dim * mult) * (dim * mult);
  endfunction

endpackage

// File: rtl/digit_vote.sv
// Consecutive-agreement vote: the output digit only changes after VOTE_N identical results in a row.
module digit_vote
  import frame_infer_pkg::*;
#(
  parameter int VOTE_N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] in_digit,
  output logic [DIGIT_W-1:0] DIGIT_OUT,
  output logic               DIGIT_VALID
);

  localparam logic [3:0] VOTE_LIM = 4'(VOTE_N);

  logic [DIGIT_W-1:0] last_digit;
  logic [3:0]         run;
  logic [3:0]         run_nxt;

  // The run saturates at VOTE_N so a long streak keeps re-confirming the same digit.
  always_comb begin
    run_nxt = 4'd1;
    if (in_digit == last_digit) begin
      run_nxt = (run >= VOTE_LIM) ? VOTE_LIM : run + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_digit  <= DIGIT_NONE;
      run         <= 4'd0;
      DIGIT_OUT   <= DIGIT_NONE;
      DIGIT_VALID <= 1'b0;
    end else if (in_valid) begin
      last_digit <= in_digit;
      run        <= run_nxt;
      if (run_nxt == VOTE_LIM) begin
        DIGIT_OUT   <= in_digit;
        DIGIT_VALID <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_infer_sched.sv
// Frame scheduler: gates capture to whole frames, starts inference, times out a hung CNN and votes digits.
// Define SCHED_STATS_EN to add the FRAMES_OK / FRAMES_BAD / LAST_RAW statistics outputs.
module frame_infer_sched
  import frame_infer_pkg::*;
#(
  parameter int PIC_DIM            = 30,
  parameter int PIC_DIM_MULTIPLIER = 3,
  parameter int FRAME_SKIP         = 2,
  parameter int VOTE_N             = 3,
  parameter int TIMEOUT_CYC        = 1000000
) (
  input  logic               VGA_CLK,
  input  logic               RESET_N,
  input  logic               VGA_VS,
  input  logic               BOX_VALID,
  output logic               CAPTURE_EN,
  output logic               CNN_START,
  input  logic               CNN_DONE,
  input  logic [DIGIT_W-1:0] CNN_DIGIT,
  output logic [DIGIT_W-1:0] DIGIT_OUT,
  output logic               DIGIT_VALID,
  output logic               FRAME_ERR,
`ifdef SCHED_STATS_EN
  output logic [15:0]        FRAMES_OK,
  output logic [15:0]        FRAMES_BAD,
  output logic [DIGIT_W-1:0] LAST_RAW,
`endif
  output sched_state_t       dbg_state
);

  localparam int EXP_PIX = box_pixels(PIC_DIM, PIC_DIM_MULTIPLIER);
  localparam int PIX_W   = $clog2(EXP_PIX) + 1;
  localparam int TMO_W   = $clog2(TIMEOUT_CYC) + 1;
  localparam int SKIP_W  = $clog2(FRAME_SKIP + 1) + 1;
  localparam logic [PIX_W-1:0]  EXP_CNT  = PIX_W'(EXP_PIX);
  localparam logic [TMO_W-1:0]  TMO_LIM  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(FRAME_SKIP);

  sched_state_t       state;
  logic               vs_q1, vs_q2;
  logic               tick;
  logic [PIX_W-1:0]   pix_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [SKIP_W-1:0]  skip_cnt;
  logic [DIGIT_W-1:0] digit_q;

  assign tick      = vs_q2 & ~vs_q1;
  assign dbg_state = state;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_q1 <= 1'b0;
      vs_q2 <= 1'b0;
    end else begin
      vs_q1 <= VGA_VS;
      vs_q2 <= vs_q1;
    end
  end

  // CNN handshake: CNN_START is a one-cycle request; the CNN answers with a one-cycle
  // CNN_DONE carrying CNN_DIGIT. Only a CNN_DONE seen in WAIT_DONE is accepted; a CNN_DONE
  // on the timeout cycle itself still wins over the timeout.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ARM;
      CAPTURE_EN <= 1'b0;
      CNN_START  <= 1'b0;
      FRAME_ERR  <= 1'b0;
      pix_cnt    <= '0;
      tmo_cnt    <= '0;
      skip_cnt   <= '0;
      digit_q    <= DIGIT_NONE;
    end else begin
      CNN_START <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        ARM: if (tick) begin
          state      <= CAPTURE;
          pix_cnt    <= '0;
          CAPTURE_EN <= 1'b1;
        end
        CAPTURE: begin
          if (BOX_VALID && pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
          if (tick) begin
            CAPTURE_EN <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (pix_cnt == EXP_CNT) begin
            state     <= START;
            CNN_START <= 1'b1;
          end else begin
            FRAME_ERR <= 1'b1;
            state     <= ARM;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (CNN_DONE) begin
            digit_q <= CNN_DIGIT;
            state   <= VOTE;
          end else if (tmo_cnt == TMO_LIM) begin
            FRAME_ERR <= 1'b1;
            skip_cnt  <= '0;
            state     <= SKIP;
          end
        end
        VOTE: begin
          skip_cnt <= '0;
          state    <= SKIP;
        end
        SKIP: begin
          if (skip_cnt == SKIP_LIM) state <= ARM;
          else if (tick) skip_cnt <= skip_cnt + 1'b1;
        end
        default: state <= ARM;
      endcase
    end
  end

  digit_vote #(.VOTE_N(VOTE_N)) u_vote (
    .clk        (VGA_CLK),
    .rst_n      (RESET_N),
    .in_valid   (state == VOTE),
    .in_digit   (digit_q),
    .DIGIT_OUT  (DIGIT_OUT),
    .DIGIT_VALID(DIGIT_VALID)
  );

`ifdef SCHED_STATS_EN
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FRAMES_OK  <= '0;
      FRAMES_BAD <= '0;
      LAST_RAW   <= DIGIT_NONE;
    end else begin
      if (state == WAIT_DONE && CNN_DONE) begin
        FRAMES_OK <= FRAMES_OK + 16'd1;
        LAST_RAW  <= CNN_DIGIT;
      end
      if (FRAME_ERR) FRAMES_BAD <= FRAMES_BAD + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_infer_sched.sv
// Directed bench for frame_infer_sched with a 16-pixel box, one skipped frame, 3-vote and 50-cycle timeout.
module tb_frame_infer_sched;
  import frame_infer_pkg::*;

  logic         VGA_CLK;
  logic         RESET_N;
  logic         VGA_VS;
  logic         BOX_VALID;
  logic         CAPTURE_EN;
  logic         CNN_START;
  logic         CNN_DONE;
  logic [3:0]   CNN_DIGIT;
  logic [3:0]   DIGIT_OUT;
  logic         DIGIT_VALID;
  logic         FRAME_ERR;
`ifdef SCHED_STATS_EN
  logic [15:0]  FRAMES_OK;
  logic [15:0]  FRAMES_BAD;
  logic [3:0]   LAST_RAW;
`endif
  sched_state_t dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  frame_infer_sched #(
    .PIC_DIM(4), .PIC_DIM_MULTIPLIER(1), .FRAME_SKIP(1), .VOTE_N(3), .TIMEOUT_CYC(50)
  ) dut (
    .VGA_CLK    (VGA_CLK),
    .RESET_N    (RESET_N),
    .VGA_VS     (VGA_VS),
    .BOX_VALID  (BOX_VALID),
    .CAPTURE_EN (CAPTURE_EN),
    .CNN_START  (CNN_START),
    .CNN_DONE   (CNN_DONE),
    .CNN_DIGIT  (CNN_DIGIT),
    .DIGIT_OUT  (DIGIT_OUT),
    .DIGIT_VALID(DIGIT_VALID),
    .FRAME_ERR  (FRAME_ERR),
`ifdef SCHED_STATS_EN
    .FRAMES_OK  (FRAMES_OK),
    .FRAMES_BAD (FRAMES_BAD),
    .LAST_RAW   (LAST_RAW),
`endif
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  task automatic step();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
  endtask

  // driver tasks
  task automatic tick_pulse();
    VGA_VS = 1'b0;
    step();
    VGA_VS = 1'b1;
    step();
  endtask

  task automatic box(input int n);
    BOX_VALID = 1'b1;
    repeat (n) step();
    BOX_VALID = 1'b0;
  endtask

  task automatic capture_to_wait();
    tick_pulse();
    check("cap_en_open", CAPTURE_EN, 1);
    check("state_capture", dbg_state, CAPTURE);
    box(16);
    check("cap_en_mid", CAPTURE_EN, 1);
    tick_pulse();
    check("cap_en_close", CAPTURE_EN, 0);
    check("start_not_yet", CNN_START, 0);
    step();
    check("cnn_start", CNN_START, 1);
    check("no_err_good", FRAME_ERR, 0);
    step();
    check("start_one_cycle", CNN_START, 0);
    check("state_wait", dbg_state, WAIT_DONE);
  endtask

  task automatic good_frame(input logic [3:0] d);
    capture_to_wait();
    CNN_DONE  = 1'b1;
    CNN_DIGIT = d;
    step();
    CNN_DONE  = 1'b0;
    check("state_vote", dbg_state, VOTE);
    step();
    check("state_skip", dbg_state, SKIP);
  endtask

  task automatic skip_frame();
    tick_pulse();
    check("skip_holds", dbg_state, SKIP);
    step();
    check("skip_to_arm", dbg_state, ARM);
  endtask

  task automatic bad_frame(input int n);
    tick_pulse();
    box(n);
    tick_pulse();
    check("bad_state_check", dbg_state, CHECK);
    step();
    check("bad_err_pulse", FRAME_ERR, 1);
    check("bad_no_start", CNN_START, 0);
    check("bad_back_arm", dbg_state, ARM);
    step();
    check("bad_err_clear", FRAME_ERR, 0);
  endtask

  initial begin
    RESET_N   = 1'b0;
    VGA_VS    = 1'b1;
    BOX_VALID = 1'b0;
    CNN_DONE  = 1'b0;
    CNN_DIGIT = 4'h0;
    step();
    step();
    check("rst_state", dbg_state, ARM);
    check("rst_cap_en", CAPTURE_EN, 0);
    check("rst_start", CNN_START, 0);
    check("rst_err", FRAME_ERR, 0);
    check("rst_digit", DIGIT_OUT, 4'hF);
    check("rst_valid", DIGIT_VALID, 0);
    RESET_N = 1'b1;
    step();
    step();

    // box pixels outside a capture window are not counted
    box(5);
    check("arm_ignores_box", CAPTURE_EN, 0);

    // three 7s, with two bad-count frames between that need no skip afterwards
    good_frame(4'd7);
    check("vote1_digit", DIGIT_OUT, 4'hF);
    check("vote1_valid", DIGIT_VALID, 0);
    skip_frame();
    bad_frame(15);
    bad_frame(17);
    good_frame(4'd7);
    check("vote2_digit", DIGIT_OUT, 4'hF);
    check("vote2_valid", DIGIT_VALID, 0);
    skip_frame();
    good_frame(4'd7);
    check("vote3_digit", DIGIT_OUT, 4'h7);
    check("vote3_valid", DIGIT_VALID, 1);
    skip_frame();

    // fresh reset, then 7,7,2,7,7,7: only the sixth result updates the output
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
    check("rst2_digit", DIGIT_OUT, 4'hF);
    good_frame(4'd7); skip_frame();
    good_frame(4'd7); skip_frame();
    check("seq_after_77", DIGIT_OUT, 4'hF);
    good_frame(4'd2); skip_frame();
    check("seq_after_2", DIGIT_OUT, 4'hF);
    good_frame(4'd7); skip_frame();
    good_frame(4'd7); skip_frame();
    check("seq_after_5", DIGIT_OUT, 4'hF);
    check("seq_valid_5", DIGIT_VALID, 0);
    good_frame(4'd7);
    check("seq_after_6", DIGIT_OUT, 4'h7);
    check("seq_valid_6", DIGIT_VALID, 1);
    skip_frame();

    // timeout: no CNN_DONE for 50 WAIT_DONE cycles
    capture_to_wait();
    repeat (49) step();
    check("tmo_wait_49", dbg_state, WAIT_DONE);
    check("tmo_no_err_49", FRAME_ERR, 0);
    step();
    check("tmo_err", FRAME_ERR, 1);
    check("tmo_to_skip", dbg_state, SKIP);
    CNN_DONE  = 1'b1;
    CNN_DIGIT = 4'd3;
    step();
    CNN_DONE  = 1'b0;
    check("late_done_state", dbg_state, SKIP);
    check("late_done_err", FRAME_ERR, 0);
    check("late_done_digit", DIGIT_OUT, 4'h7);
    skip_frame();

    // CNN_DONE on the 50th WAIT_DONE cycle beats the timeout
    capture_to_wait();
    repeat (49) step();
    CNN_DONE  = 1'b1;
    CNN_DIGIT = 4'd5;
    step();
    CNN_DONE  = 1'b0;
    check("edge_done_vote", dbg_state, VOTE);
    check("edge_done_no_err", FRAME_ERR, 0);
    step();
    check("edge_no_err_after", FRAME_ERR, 0);
    check("edge_digit_held", DIGIT_OUT, 4'h7);
    skip_frame();

    // asynchronous reset in WAIT_DONE, mid clock period
    capture_to_wait();
    step();
    RESET_N = 1'b0;
    #2;
    check("arst_state", dbg_state, ARM);
    check("arst_digit", DIGIT_OUT, 4'hF);
    check("arst_valid", DIGIT_VALID, 0);
    check("arst_cap_en", CAPTURE_EN, 0);
    check("arst_err", FRAME_ERR, 0);
    step();
    RESET_N = 1'b1;
    repeat (5) step();
    check("post_rst_arm", dbg_state, ARM);
    check("post_rst_cap_en", CAPTURE_EN, 0);
    tick_pulse();
    check("post_rst_capture", CAPTURE_EN, 1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
